hyper_cmd_seq: RTL and testbench



---
 rtl/hyper_cmd_seq.sv | 216 +++++++++++++++++++++
 tb/tb_hyper_cmd_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_cmd_seq.sv
// Command sequencer in front of hyper_xface: power-up hold-off, command FIFO,
// one-at-a-time request issue and read-data return.
module hyper_cmd_seq #(
    parameter int STARTUP_CYCLES = 1800,
    parameter int FIFO_DEPTH     = 4,
    parameter int BUSY_TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        init_done,
    output logic        err,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] addr,
    output logic [31:0] wr_d,
    output logic [3:0]  wr_byte_en,
    output logic [5:0]  rd_num_dwords,
    input  logic        busy,
    input  logic [31:0] rd_d
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(STARTUP_CYCLES + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int EW = 1 + 32 + 32 + 4;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] st_cnt_q, st_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          init_q, init_d;
    logic          err_q, err_d;
    logic          cur_we_q, cur_we_d;
    logic          rd_req_q, rd_req_d;
    logic          wr_req_q, wr_req_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wr_d_q, wr_d_d;
    logic [3:0]    be_q, be_d;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic          head_we;
    logic [31:0]   head_addr;
    logic [31:0]   head_wdata;
    logic [3:0]    head_be;

    assign cmd_ready  = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem_q[rd_ptr_q];
    assign head_we    = head[EW-1];
    assign head_addr  = head[67:36];
    assign head_wdata = head[35:4];
    assign head_be    = head[3:0];

    // Entry layout {we, addr, wdata, be}; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_we, cmd_addr, cmd_wdata, cmd_be};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        st_cnt_d    = st_cnt_q;
        tmo_d       = tmo_q;
        init_d      = init_q;
        err_d       = err_q;
        cur_we_d    = cur_we_q;
        addr_d      = addr_q;
        wr_d_d      = wr_d_q;
        be_d        = be_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                st_cnt_d = st_cnt_q + CW'(1);
                if (st_cnt_q == CW'(STARTUP_CYCLES - 1)) begin
                    init_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Request strobes are registered so they are high exactly during ISSUE.
                if ((count_q != '0) && !busy) begin
                    pop      = 1'b1;
                    cur_we_d = head_we;
                    addr_d   = head_addr;
                    wr_d_d   = head_wdata;
                    be_d     = head_we ? head_be : 4'h0;
                    rd_req_d = !head_we;
                    wr_req_d = head_we;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(BUSY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    if (!cur_we_q) begin
                        rsp_data_d  = rd_d;
                        rsp_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_STARTUP;
            st_cnt_q    <= '0;
            tmo_q       <= '0;
            init_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_we_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            wr_d_q      <= '0;
            be_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            st_cnt_q    <= st_cnt_d;
            tmo_q       <= tmo_d;
            init_q      <= init_d;
            err_q       <= err_d;
            cur_we_q    <= cur_we_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            addr_q      <= addr_d;
            wr_d_q      <= wr_d_d;
            be_q        <= be_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign init_done     = init_q;
    assign err           = err_q;
    assign rd_req        = rd_req_q;
    assign wr_req        = wr_req_q;
    assign addr          = addr_q;
    assign wr_d          = wr_d_q;
    assign wr_byte_en    = be_q;
    assign rd_num_dwords = 6'h1;

endmodule

// File: tb/tb_hyper_cmd_seq.sv
// Bench for hyper_cmd_seq: transaction-level model plus a small bus responder,
// driven by directed command sequences.
module tb_hyper_cmd_seq;

    localparam int S     = 20;
    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        init_done;
    logic        err;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_d;
    logic [3:0]  wr_byte_en;
    logic [5:0]  rd_num_dwords;
    wire         busy;
    logic [31:0] rd_d;

    logic        hold_busy;
    logic        bm_busy;
    logic        bm_never;
    int          bm_len;
    logic [31:0] bm_rdata;

    assign busy = hold_busy | bm_busy;

    hyper_cmd_seq #(
        .STARTUP_CYCLES(S),
        .FIFO_DEPTH    (DEPTH),
        .BUSY_TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_be       (cmd_be),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .err          (err),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .addr         (addr),
        .wr_d         (wr_d),
        .wr_byte_en   (wr_byte_en),
        .rd_num_dwords(rd_num_dwords),
        .busy         (busy),
        .rd_d         (rd_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Transaction-level model: queued commands, one command in flight, and
    // what the request side and response side must show each cycle.
    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        m_cur;
    cmd_t        c_new;
    int          cyc;
    bit          m_init, m_have, m_rsp, m_err;
    int          m_ph, m_low;
    logic [31:0] m_addr, m_wd, m_rdata;
    logic [3:0]  m_be;
    bit          p_init, p_have;
    int          p_size;

    always @(posedge clk) begin
        if (reset) begin
            cyc = 0; m_init = 0; m_have = 0; m_ph = 0; m_low = 0; m_err = 0; m_rsp = 0;
            m_rdata = 0; m_addr = 0; m_wd = 0; m_be = 0;
            mq.delete();
        end else begin
            p_init = m_init;
            p_have = m_have;
            p_size = mq.size();
            m_rsp  = 0;
            if (p_have) begin
                if (m_ph == 0) begin
                    m_ph = 1; m_low = 0;
                end else if (m_ph == 1) begin
                    if (busy) m_ph = 2;
                    else begin
                        m_low++;
                        if (m_low == TO) begin m_err = 1; m_have = 0; end
                    end
                end else if (!busy) begin
                    if (!m_cur.we) begin m_rsp = 1; m_rdata = rd_d; end
                    m_have = 0;
                end
            end
            if (p_init && !p_have && p_size > 0 && !busy) begin
                m_cur  = mq.pop_front();
                m_have = 1; m_ph = 0;
                m_addr = m_cur.a; m_wd = m_cur.d;
                m_be   = m_cur.we ? m_cur.be : 4'h0;
            end
            if (cmd_valid && p_size < DEPTH) begin
                c_new.we = cmd_we; c_new.a = cmd_addr; c_new.d = cmd_wdata; c_new.be = cmd_be;
                mq.push_back(c_new);
            end
            cyc++;
            if (cyc >= S) m_init = 1;
        end
    end

    int          n_rd = 0, n_wr = 0, n_rsp = 0;
    logic [31:0] req_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("cmd_ready", cmd_ready, mq.size() < DEPTH);
            chk1("init_done", init_done, m_init);
            chk1("err", err, m_err);
            chk1("rd_req", rd_req, m_have && m_ph == 0 && !m_cur.we);
            chk1("wr_req", wr_req, m_have && m_ph == 0 && m_cur.we);
            chk1("rsp_valid", rsp_valid, m_rsp);
            chk("rsp_data", rsp_data, m_rdata);
            chk("addr", addr, m_addr);
            chk("wr_byte_en", {28'b0, wr_byte_en}, {28'b0, m_be});
            chk("rd_num_dwords", {26'b0, rd_num_dwords}, 32'h1);
            if (m_have && m_ph == 0 && m_cur.we) chk("wr_d", wr_d, m_wd);
            if (rd_req) n_rd++;
            if (wr_req) n_wr++;
            if (rsp_valid) n_rsp++;
            if (rd_req || wr_req) req_q.push_back(addr);
        end
    end

    // Bus responder: busy rises in the request cycle, stays high bm_len cycles,
    // rd_d is valid as busy falls and is scrambled one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if ((rd_req || wr_req) && !bm_never) begin
                bm_busy = 1'b1;
                repeat (bm_len) @(negedge clk);
                rd_d    = bm_rdata;
                bm_busy = 1'b0;
                @(negedge clk);
                rd_d = 32'h0BADF00D;
            end
        end
    end

    function automatic logic sel_sig(input int s);
        case (s)
            0:       return rd_req;
            1:       return wr_req;
            2:       return rsp_valid;
            3:       return init_done;
            default: return err;
        endcase
    endfunction

    task automatic wait_sig(input int s, input int lim, input string name);
        int n;
        n = 0;
        while (!sel_sig(s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk1(name, sel_sig(s), 1'b1);
    endtask

    // Call just after a falling edge; returns on the falling edge after acceptance.
    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_be = be; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("push_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_rd_req"}, rd_req, 1'b0);
        chk1({tag, "_wr_req"}, wr_req, 1'b0);
        chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk1({tag, "_init_done"}, init_done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_addr"}, addr, 32'h0);
        chk({tag, "_wr_d"}, wr_d, 32'h0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_be"}, {28'b0, wr_byte_en}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    int pc, rc, r0, q0;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        hold_busy = 1'b0; bm_busy = 1'b0; bm_never = 1'b0; bm_len = 3; bm_rdata = '0; rd_d = '0;
        @(posedge clk);
        chk_en = 1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Startup hold-off with a write buffered during STARTUP
        @(negedge clk);
        chk1("t1_ready_at_push", cmd_ready, 1'b1);
        push(1'b1, 32'h100, 32'h11112222, 4'hF);
        wait_sig(3, 100, "t1_init_seen");
        #1;
        chk("t1_init_cycle", cyc, 32'd20);
        chk("t1_no_early_wr", n_wr, 32'd0);
        wait_sig(1, 20, "t1_wr_seen");
        repeat (10) @(negedge clk);
        #1;
        chk("t1_wr_count", n_wr, 32'd1);

        // Write pass-through
        r0 = n_rsp;
        push(1'b1, 32'h012345, 32'h0000ABCD, 4'h3);
        pc = cyc;
        wait_sig(1, 20, "t2_wr_seen");
        chk("t2_latency", cyc - pc, 32'd1);
        chk("t2_addr", addr, 32'h012345);
        chk("t2_wr_d", wr_d, 32'h0000ABCD);
        chk("t2_be", {28'b0, wr_byte_en}, 32'h3);
        repeat (10) @(negedge clk);
        #1;
        chk("t2_no_rsp", n_rsp - r0, 32'd0);

        // Read return
        bm_len = 10; bm_rdata = 32'hDEADBEEF; r0 = n_rsp;
        push(1'b0, 32'h6789AB, 32'h0, 4'hF);
        wait_sig(0, 20, "t3_rd_seen");
        chk("t3_addr", addr, 32'h6789AB);
        chk("t3_be", {28'b0, wr_byte_en}, 32'h0);
        chk("t3_ndw", {26'b0, rd_num_dwords}, 32'h1);
        wait_sig(2, 40, "t3_rsp_seen");
        chk("t3_rsp_data", rsp_data, 32'hDEADBEEF);
        @(negedge clk);
        chk1("t3_rsp_one_cycle", rsp_valid, 1'b0);
        chk("t3_rsp_held", rsp_data, 32'hDEADBEEF);
        repeat (5) @(negedge clk);
        #1;
        chk("t3_rsp_count", n_rsp - r0, 32'd1);
        bm_len = 3;

        // FIFO full and ordering
        req_q.delete();
        hold_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(1'b1, 32'(i), 32'(i) * 32'h1111, 4'(i));
        chk1("t4_full", cmd_ready, 1'b0);
        fork
            push(1'b1, 32'd5, 32'h5555, 4'h5);
            begin
                repeat (3) @(negedge clk);
                chk1("t4_still_full", cmd_ready, 1'b0);
                hold_busy = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        #1;
        chk("t4_req_count", req_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < req_q.size()) chk("t4_order", req_q[i], 32'(i + 1));
        end

        // Busy timeout
        bm_never = 1'b1; r0 = n_rsp;
        chk1("t5_err_before", err, 1'b0);
        push(1'b0, 32'h77, 32'h0, 4'h0);
        wait_sig(0, 20, "t5_rd_seen");
        rc = cyc;
        push(1'b1, 32'h88, 32'h5A5A5A5A, 4'hC);
        wait_sig(4, 40, "t5_err_seen");
        chk("t5_err_latency", cyc - rc, 32'd16);
        wait_sig(1, 20, "t5_next_wr_seen");
        chk("t5_next_addr", addr, 32'h88);
        chk("t5_next_be", {28'b0, wr_byte_en}, 32'hC);
        repeat (20) @(negedge clk);
        #1;
        chk1("t5_err_sticky", err, 1'b1);
        chk("t5_no_rsp", n_rsp - r0, 32'd0);
        bm_never = 1'b0;

        // Reset in WAIT_DONE with two commands queued
        bm_len = 30;
        push(1'b0, 32'hA0, 32'h0, 4'h0);
        wait_sig(0, 20, "t6_rd_seen");
        push(1'b1, 32'hB0, 32'h1234, 4'hF);
        push(1'b0, 32'hC0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        r0 = n_rsp; q0 = n_rd + n_wr;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6");
        reset = 1'b0;
        wait_sig(3, 60, "t6_init_seen");
        #1;
        chk("t6_init_cycle", cyc, 32'd20);
        repeat (40) @(negedge clk);
        #1;
        chk("t6_no_rsp", n_rsp - r0, 32'd0);
        chk("t6_no_req", n_rd + n_wr - q0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
